// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_W data bits LSB first, optional parity, 1-2 stops.
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 2604,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_vld,
  output logic              tx_rdy,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BW-1:0]     baud;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] shreg;
  logic              hold_full;
  logic              accept;
  logic              bit_tick;
  logic              last_bit;
  logic              frame_end;
  logic              load;
  logic              tx_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  assign tx_rdy    = ~hold_full & ~rst;
  assign accept    = tx_vld & tx_rdy;
  assign bit_tick  = (state != IDLE) && (baud == BW'(CLK_DIV - 1));
  assign frame_end = (state == STOP) && bit_tick && last_bit;
  assign load      = hold_full && ((state == IDLE) || frame_end);

  always_comb begin
    last_bit = 1'b1;
    if (state == DATA)
      last_bit = (bit_cnt == CW'(DATA_W - 1));
    else if (state == STOP)
      last_bit = (bit_cnt == CW'(STOP_BITS - 1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (hold_full)
          state_nxt = START;
      START:
        if (bit_tick)
          state_nxt = DATA;
      DATA:
        if (bit_tick && last_bit)
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
      PARITY:
        if (bit_tick)
          state_nxt = STOP;
      STOP:
        if (frame_end)
          state_nxt = hold_full ? START : IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (load)
      par <= (^hold) ^ PARITY_ODD[0];
  end
`endif

  // tx/busy/done are registered from the current state, so they lag it by one clock.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state != IDLE);
    done_nxt = frame_end;
    unique case (state)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = par;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      tx_busy <= busy_nxt;
      tx_done <= done_nxt;
      if (state == IDLE || state_nxt != state || bit_tick)
        baud <= '0;
      else
        baud <= baud + 1'b1;
      if (state_nxt != state)
        bit_cnt <= '0;
      else if (bit_tick && (state == DATA || state == STOP))
        bit_cnt <= bit_cnt + 1'b1;
      if (accept)
        hold_full <= 1'b1;
      else if (load)
        hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      hold <= tx_data;
    if (load)
      shreg <= hold;
    else if (state == DATA && bit_tick)
      shreg <= shreg >> 1;
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8-bit/1-stop and 7-bit/2-stop instances, CLK_DIV=16.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
  localparam int FL8 = 176;
  localparam int FL7 = 176;
`else
  localparam int PAR = 0;
  localparam int FL8 = 160;
  localparam int FL7 = 160;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data0 = '0;
  logic [6:0] tx_data1 = '0;
  logic       vld0 = 1'b0;
  logic       vld1 = 1'b0;
  logic       rdy0, tx0, busy0, done0;
  logic       rdy1, tx1, busy1, done1;

  int total = 0;
  int bad   = 0;

  logic r_tx   [0:399];
  logic r_busy [0:399];
  logic r_done [0:399];
  logic r_rdy  [0:399];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(8), .CLK_DIV(16), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_vld(vld0),
    .tx_rdy(rdy0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx_param #(.DATA_W(7), .CLK_DIV(16), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_vld(vld1),
    .tx_rdy(rdy1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
  );

  function automatic int flen(input int dw, input int sb);
    return (1 + dw + PAR + sb) * 16;
  endfunction

  function automatic logic exp_tx(input int dw, input int sb, input int podd,
                                  input logic [8:0] d, input int i);
    int   b;
    logic p;
    p = podd[0];
    for (int k = 0; k < dw; k++)
      p = p ^ d[k];
    if (i < 0 || i >= flen(dw, sb))
      return 1'b1;
    b = i / 16;
    if (b == 0)
      return 1'b0;
    if (b <= dw)
      return d[b-1];
    if (PAR == 1 && b == dw + 1)
      return p;
    return 1'b1;
  endfunction

  task automatic record(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      r_tx[i]   = sel == 0 ? tx0   : tx1;
      r_busy[i] = sel == 0 ? busy0 : busy1;
      r_done[i] = sel == 0 ? done0 : done1;
      r_rdy[i]  = sel == 0 ? rdy0  : rdy1;
      @(negedge clk);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      tx_data0 = d;
      vld0 = 1'b1;
    end else begin
      tx_data1 = d[6:0];
      vld1 = 1'b1;
    end
    @(negedge clk);
    vld0 = 1'b0;
    vld1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_out tx=%b busy=%b done=%b want 1 0 0", tx0, busy0, done0);
    end
    total++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_rdy rdy0=%b rdy1=%b want 0 0", rdy0, rdy1);
    end
    rst = 1'b0;
    #1;
    total++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      bad++;
      $display("FAIL rdy_after_reset rdy0=%b rdy1=%b want 1 1", rdy0, rdy1);
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [8:0] d;
    d = 9'h0A5;
    total++;
    if (rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL single_rdy got=%b want=1", rdy0);
    end
    send(0, d[7:0]);
    @(negedge clk);
    total++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL single_latency tx=%b busy=%b want 1 0", tx0, busy0);
    end
    @(negedge clk);
    record(0, FL8 + 2);
    for (int i = 0; i < FL8 + 2; i++) begin
      total++;
      if (r_tx[i] !== exp_tx(8, 1, 0, d, i) || r_busy[i] !== (i < FL8) ||
          r_done[i] !== (i == FL8 - 1)) begin
        bad++;
        $display("FAIL single_a5 clk=%0d tx/busy/done=%b%b%b want %b%b%b", i,
                 r_tx[i], r_busy[i], r_done[i], exp_tx(8, 1, 0, d, i),
                 i < FL8, i == FL8 - 1);
      end
    end
    total++;
    if (r_tx[16] !== 1'b1 || r_tx[32] !== 1'b0 || r_tx[48] !== 1'b1 ||
        r_tx[96] !== 1'b1 || r_tx[128] !== 1'b1 || r_done[FL8-1] !== 1'b1) begin
      bad++;
      $display("FAIL single_hand b0=%b b1=%b b2=%b b5=%b b7=%b done=%b want 101111",
               r_tx[16], r_tx[32], r_tx[48], r_tx[96], r_tx[128], r_done[FL8-1]);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] a, b;
    a = 9'h000;
    b = 9'h0FF;
    total++;
    if (rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rdy0 got=%b want=1", rdy0);
    end
    tx_data0 = a[7:0];
    vld0 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_rdy_after_accept got=%b want=0", rdy0);
    end
    tx_data0 = b[7:0];
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rdy_after_load got=%b want=1", rdy0);
    end
    @(negedge clk);
    vld0 = 1'b0;
    record(0, 2 * FL8 + 2);
    for (int i = 0; i < 2 * FL8 + 2; i++) begin
      logic et;
      et = i < FL8 ? exp_tx(8, 1, 0, a, i) : exp_tx(8, 1, 0, b, i - FL8);
      total++;
      if (r_tx[i] !== et || r_busy[i] !== (i < 2 * FL8) ||
          r_done[i] !== (i == FL8 - 1 || i == 2 * FL8 - 1) ||
          r_rdy[i] !== (i >= FL8 - 1)) begin
        bad++;
        $display("FAIL b2b clk=%0d tx/busy/done/rdy=%b%b%b%b want %b%b%b%b", i,
                 r_tx[i], r_busy[i], r_done[i], r_rdy[i], et, i < 2 * FL8,
                 i == FL8 - 1 || i == 2 * FL8 - 1, i >= FL8 - 1);
      end
    end
  endtask

  task automatic test_parity;
    logic [8:0] d;
    d = 9'h007;
    send(0, d[7:0]);
    repeat (2) @(negedge clk);
    record(0, FL8 + 2);
    for (int i = 0; i < FL8 + 2; i++) begin
      total++;
      if (r_tx[i] !== exp_tx(8, 1, 0, d, i) || r_done[i] !== (i == FL8 - 1)) begin
        bad++;
        $display("FAIL parity_frame clk=%0d tx/done=%b%b want %b%b", i, r_tx[i],
                 r_done[i], exp_tx(8, 1, 0, d, i), i == FL8 - 1);
      end
    end
`ifdef UART_TX_PARITY_EN
    total++;
    if (r_tx[9*16+8] !== 1'b1 || r_done[175] !== 1'b1) begin
      bad++;
      $display("FAIL parity_even bit=%b done175=%b want 1 1", r_tx[9*16+8], r_done[175]);
    end
    send(1, d[7:0]);
    repeat (2) @(negedge clk);
    record(1, FL7 + 2);
    total++;
    if (r_tx[8*16+8] !== 1'b0) begin
      bad++;
      $display("FAIL parity_odd bit=%b want 0", r_tx[8*16+8]);
    end
`endif
  endtask

  task automatic test_param;
    logic [8:0] d;
    d = 9'h055;
    total++;
    if (rdy1 !== 1'b1) begin
      bad++;
      $display("FAIL param_rdy got=%b want=1", rdy1);
    end
    send(1, d[7:0]);
    repeat (2) @(negedge clk);
    record(1, FL7 + 2);
    for (int i = 0; i < FL7 + 2; i++) begin
      total++;
      if (r_tx[i] !== exp_tx(7, 2, 1, d, i) || r_busy[i] !== (i < FL7) ||
          r_done[i] !== (i == FL7 - 1)) begin
        bad++;
        $display("FAIL param_55 clk=%0d tx/busy/done=%b%b%b want %b%b%b", i,
                 r_tx[i], r_busy[i], r_done[i], exp_tx(7, 2, 1, d, i),
                 i < FL7, i == FL7 - 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] d;
    int lows, dones;
    tx_data0 = 8'hC3;
    vld0 = 1'b1;
    @(negedge clk);
    tx_data0 = 8'h99;
    @(negedge clk);
    @(negedge clk);
    vld0 = 1'b0;
    repeat (70) @(negedge clk);
    total++;
    if (tx0 !== 1'b0 || rdy0 !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre tx=%b rdy=%b want 0 0", tx0, rdy0);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || rdy0 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset tx/busy/done/rdy=%b%b%b%b want 1000", tx0, busy0, done0, rdy0);
    end
    rst = 1'b0;
    #1;
    total++;
    if (rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL mid_hold_empty rdy=%b want 1", rdy0);
    end
    lows = 0;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
      if (done0 !== 1'b0) dones++;
    end
    total++;
    if (lows != 0 || dones != 0) begin
      bad++;
      $display("FAIL mid_quiet low_clks=%0d done_clks=%0d want 0 0", lows, dones);
    end
    d = 9'h03C;
    send(0, d[7:0]);
    repeat (2) @(negedge clk);
    record(0, FL8 + 2);
    for (int i = 0; i < FL8 + 2; i++) begin
      total++;
      if (r_tx[i] !== exp_tx(8, 1, 0, d, i) || r_done[i] !== (i == FL8 - 1)) begin
        bad++;
        $display("FAIL mid_3c clk=%0d tx/done=%b%b want %b%b", i, r_tx[i],
                 r_done[i], exp_tx(8, 1, 0, d, i), i == FL8 - 1);
      end
    end
  endtask

  task automatic test_ignore;
    logic [8:0] a, b;
    int rdy_hi;
    a = 9'h081;
    b = 9'h05A;
    tx_data0 = a[7:0];
    vld0 = 1'b1;
    @(negedge clk);
    tx_data0 = b[7:0];
    @(negedge clk);
    @(negedge clk);
    rdy_hi = 0;
    fork
      record(0, 2 * FL8 + 2);
      begin
        for (int i = 0; i < 100; i++) begin
          tx_data0 = 8'($urandom);
          if (rdy0 !== 1'b0) rdy_hi++;
          @(negedge clk);
        end
        vld0 = 1'b0;
      end
    join
    total++;
    if (rdy_hi != 0) begin
      bad++;
      $display("FAIL ignore_rdy high_clks=%0d want 0", rdy_hi);
    end
    for (int i = 0; i < 2 * FL8 + 2; i++) begin
      logic et;
      et = i < FL8 ? exp_tx(8, 1, 0, a, i) : exp_tx(8, 1, 0, b, i - FL8);
      total++;
      if (r_tx[i] !== et) begin
        bad++;
        $display("FAIL ignore_word clk=%0d tx=%b want %b", i, r_tx[i], et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_param();
    test_reset_mid();
    test_ignore();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
